// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared funct3 encodings, divider state encoding and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam logic [2:0] FUNCT3_DIV  = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU = 3'b101;
    localparam logic [2:0] FUNCT3_REM  = 3'b110;
    localparam logic [2:0] FUNCT3_REMU = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } div_state_e;

    // Two's-complement negate when i_neg is set, pass through otherwise.
    function automatic logic [31:0] neg_if(input logic i_neg, input logic [31:0] i_val);
        return i_neg ? (~i_val + 32'd1) : i_val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_if.sv
`default_nettype none
// ============================================================================
// Module      : div_if
// Description : Request/writeback bundle between issue logic and the divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_if #(
    parameter int XLEN = 32
);
    logic            div_request_i;
    logic [31:0]     inst_i;
    logic [XLEN-1:0] rs1_value_i;
    logic [XLEN-1:0] rs2_value_i;
    logic            busy_o;
    logic            writeback_valid_o;
    logic [XLEN-1:0] writeback_value_o;

    modport master (
        output div_request_i,
        output inst_i,
        output rs1_value_i,
        output rs2_value_i,
        input  busy_o,
        input  writeback_valid_o,
        input  writeback_value_o
    );

    modport slave (
        input  div_request_i,
        input  inst_i,
        input  rs1_value_i,
        input  rs2_value_i,
        output busy_o,
        output writeback_valid_o,
        output writeback_value_o
    );
endinterface
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One restoring shift-subtract-select step on unsigned values.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int XLEN = 32
) (
    input  wire logic [XLEN-1:0] i_rem,
    input  wire logic [XLEN-1:0] i_dividend,
    input  wire logic [XLEN-1:0] i_divisor,
    output logic      [XLEN-1:0] o_rem,
    output logic      [XLEN-1:0] o_dividend
);

    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;

    // The remainder stays below the divisor, so the shifted value never needs
    // more than one extra bit and w_diff's MSB is a clean borrow flag.
    assign w_shift    = {i_rem, i_dividend[XLEN-1]};
    assign w_diff     = w_shift - {1'b0, i_divisor};
    assign o_rem      = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
    assign o_dividend = {i_dividend[XLEN-2:0], ~w_diff[XLEN]};

endmodule
`default_nettype wire

// File: rtl/div.sv
`default_nettype none
// ============================================================================
// Module      : div
// Description : Iterative radix-2 DIV/DIVU/REM/REMU unit with busy stall.
//               Define DIV_FAST_SPECIAL_EN for a one-cycle divide-by-zero and
//               signed-overflow path.
// Revision    : 1.0 - initial release
// ============================================================================
module div
    import div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic clk_i,
    input  wire logic reset_i,
    div_if.slave      bus
);

    localparam int c_cnt_w = $clog2(XLEN);

    div_state_e       r_state;
    div_state_e       w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [XLEN-1:0]  r_quot;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_divisor;
    logic [XLEN-1:0]  r_result;
    logic             r_sel_rem;
    logic             r_neg_q;
    logic             r_neg_r;

    logic [2:0]       w_funct3;
    logic             w_accept;
    logic             w_signed;
    logic             w_rs2_zero;
    logic [XLEN-1:0]  w_mag1;
    logic [XLEN-1:0]  w_mag2;
    logic             w_neg_q;
    logic             w_neg_r;
    logic             w_fast;
    logic [XLEN-1:0]  w_fast_result;
    logic [XLEN-1:0]  w_step_rem;
    logic [XLEN-1:0]  w_step_quot;
    logic [XLEN-1:0]  w_quot_fix;
    logic [XLEN-1:0]  w_rem_fix;
    logic             w_unused_inst;

    assign w_funct3      = bus.inst_i[14:12];
    assign w_unused_inst = ^{bus.inst_i[31:15], bus.inst_i[11:0]};
    assign w_accept      = (r_state == S_IDLE) && bus.div_request_i && w_funct3[2];
    assign w_signed      = ~w_funct3[0];
    assign w_rs2_zero    = (bus.rs2_value_i == '0);
    assign w_mag1        = neg_if(w_signed & bus.rs1_value_i[XLEN-1], bus.rs1_value_i);
    assign w_mag2        = neg_if(w_signed & bus.rs2_value_i[XLEN-1], bus.rs2_value_i);
    assign w_neg_q       = (bus.rs1_value_i[XLEN-1] ^ bus.rs2_value_i[XLEN-1])
                           & w_signed & ~w_rs2_zero;
    assign w_neg_r       = bus.rs1_value_i[XLEN-1] & w_signed;

`ifdef DIV_FAST_SPECIAL_EN
    logic w_ovf;
    assign w_ovf  = w_signed && (bus.rs1_value_i == {1'b1, {(XLEN-1){1'b0}}})
                    && (bus.rs2_value_i == '1);
    assign w_fast = w_rs2_zero | w_ovf;
    // Both special cases reduce to either all-ones, zero or the raw dividend.
    always_comb begin
        w_fast_result = '0;
        if (w_rs2_zero)
            w_fast_result = w_funct3[1] ? bus.rs1_value_i : '1;
        else
            w_fast_result = w_funct3[1] ? '0 : bus.rs1_value_i;
    end
`else
    assign w_fast        = 1'b0;
    assign w_fast_result = '0;
`endif

    div_step #(
        .XLEN(XLEN)
    ) u_step (
        .i_rem      (r_rem),
        .i_dividend (r_quot),
        .i_divisor  (r_divisor),
        .o_rem      (w_step_rem),
        .o_dividend (w_step_quot)
    );

    assign w_quot_fix = neg_if(r_neg_q, r_quot);
    assign w_rem_fix  = neg_if(r_neg_r, r_rem);

    always_ff @(posedge clk_i) begin
        if (reset_i)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt           = r_state;
        bus.busy_o            = 1'b0;
        bus.writeback_valid_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_state_nxt = w_fast ? S_DONE : S_CALC;
            end
            S_CALC: begin
                bus.busy_o = 1'b1;
                if (r_cnt == '0)
                    w_state_nxt = S_FIXUP;
            end
            S_FIXUP: begin
                bus.busy_o  = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                bus.busy_o            = 1'b1;
                bus.writeback_valid_o = 1'b1;
                w_state_nxt           = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // r_quot starts as the dividend magnitude and fills with quotient bits
    // as the dividend bits shift out of its top.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cnt     <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_result  <= '0;
            r_sel_rem <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt     <= c_cnt_w'(XLEN - 1);
                        r_quot    <= w_mag1;
                        r_rem     <= '0;
                        r_divisor <= w_mag2;
                        r_sel_rem <= w_funct3[1];
                        r_neg_q   <= w_neg_q;
                        r_neg_r   <= w_neg_r;
                        if (w_fast)
                            r_result <= w_fast_result;
                    end
                end
                S_CALC: begin
                    r_rem  <= w_step_rem;
                    r_quot <= w_step_quot;
                    r_cnt  <= r_cnt - c_cnt_w'(1);
                end
                S_FIXUP: begin
                    r_result <= r_sel_rem ? w_rem_fix : w_quot_fix;
                end
                default: ;
            endcase
        end
    end

    assign bus.writeback_value_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_div
// Description : Directed and random self-checking bench for the divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div;
    import div_pkg::*;

`ifdef DIV_FAST_SPECIAL_EN
    localparam int FAST_LAT = 1;
`else
    localparam int FAST_LAT = 34;
`endif

    typedef struct {
        logic [31:0] val;
        int          lat;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        reset_i;
    exp_t        exp_q[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    logic [31:0] last_val = 32'h0;

    div_if #(.XLEN(32)) bus();

    div #(.XLEN(32)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            FUNCT3_DIV:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
            FUNCT3_REM:  return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
            FUNCT3_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default:     return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        logic special;
        special = (b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return special ? FAST_LAT : 34;
    endfunction

    task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bus.inst_i        = {7'b0000001, 10'h0, f3, 5'h0, 7'b0110011};
        bus.rs1_value_i   = a;
        bus.rs2_value_i   = b;
        bus.div_request_i = 1'b1;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        exp_t e;
        int   lat;
        bit   seen;
        @(negedge clk_i);
        drive(f3, a, b);
        e.val = exp;
        e.lat = exp_lat(f3, a, b);
        exp_q.push_back(e);
        lat  = 0;
        seen = 0;
        while (!seen && lat < 100) begin
            @(negedge clk_i);
            lat++;
            if (lat == 1) begin
                bus.div_request_i = 1'b0;
                chk({tag, "/busy1"}, 32'(bus.busy_o), 32'h1);
            end
            if (bus.writeback_valid_o)
                seen = 1;
            else
                chk({tag, "/hold"}, bus.writeback_value_o, last_val);
        end
        e = exp_q.pop_front();
        if (!seen) begin
            n_vec++;
            n_fail++;
            $error("FAIL %s/timeout: observed no valid expected valid", tag);
        end else begin
            chk({tag, "/val"}, bus.writeback_value_o, e.val);
            chk({tag, "/lat"}, 32'(lat), 32'(e.lat));
            last_val = e.val;
            @(negedge clk_i);
            chk({tag, "/pulse"}, 32'(bus.writeback_valid_o), 32'h0);
            chk({tag, "/stable"}, bus.writeback_value_o, e.val);
            chk({tag, "/idle"}, 32'(bus.busy_o), 32'h0);
        end
    endtask

    initial begin
        int          pulses;
        int          busy_cnt;
        int          plat;
        logic [31:0] pval;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;

        reset_i           = 1'b1;
        bus.div_request_i = 1'b0;
        bus.inst_i        = 32'h0;
        bus.rs1_value_i   = 32'h0;
        bus.rs2_value_i   = 32'h0;
        repeat (3) @(negedge clk_i);
        chk("rst/busy", 32'(bus.busy_o), 32'h0);
        chk("rst/valid", 32'(bus.writeback_valid_o), 32'h0);
        chk("rst/value", bus.writeback_value_o, 32'h0);
        reset_i = 1'b0;

        run_op("div_20_m3", FUNCT3_DIV, 32'h0000_0014, 32'hFFFF_FFFD, 32'hFFFF_FFFA);
        run_op("rem_20_m3", FUNCT3_REM, 32'h0000_0014, 32'hFFFF_FFFD, 32'h0000_0002);
        run_op("divu_max_2", FUNCT3_DIVU, 32'hFFFF_FFFF, 32'h2, 32'h7FFF_FFFF);
        run_op("remu_max_2", FUNCT3_REMU, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001);
        run_op("rem_m7_2", FUNCT3_REM, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF);
        run_op("divu_7_0", FUNCT3_DIVU, 32'h7, 32'h0, 32'hFFFF_FFFF);
        run_op("remu_7_0", FUNCT3_REMU, 32'h7, 32'h0, 32'h0000_0007);
        run_op("div_m5_0", FUNCT3_DIV, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFF);
        run_op("rem_m5_0", FUNCT3_REM, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB);
        run_op("div_ovf", FUNCT3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf", FUNCT3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

        for (int i = 0; i < 8; i++) begin
            f3 = 3'(4 + $urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if (i % 2 == 1)
                b = b >> $urandom_range(16, 30);
            run_op("rand", f3, a, b, ref_div(f3, a, b));
        end

        // A request landing in cycle 5 must be dropped while the first runs.
        @(negedge clk_i);
        drive(FUNCT3_DIVU, 32'd100, 32'd7);
        pulses = 0;
        plat   = 0;
        pval   = 32'h0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk_i);
            if (c == 1 || c == 6)
                bus.div_request_i = 1'b0;
            if (c == 5)
                drive(FUNCT3_DIVU, 32'd50, 32'd5);
            if (bus.writeback_valid_o) begin
                pulses++;
                if (pulses == 1) begin
                    plat = c;
                    pval = bus.writeback_value_o;
                end
            end
        end
        chk("busyreq/pulses", 32'(pulses), 32'h1);
        chk("busyreq/val", pval, 32'd14);
        chk("busyreq/lat", 32'(plat), 32'd34);
        last_val = 32'd14;

        @(negedge clk_i);
        drive(3'b000, 32'd10, 32'd2);
        busy_cnt = 0;
        pulses   = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_i);
            if (c == 1)
                bus.div_request_i = 1'b0;
            if (bus.busy_o)
                busy_cnt++;
            if (bus.writeback_valid_o)
                pulses++;
        end
        chk("f3zero/busy", 32'(busy_cnt), 32'h0);
        chk("f3zero/pulses", 32'(pulses), 32'h0);
        chk("f3zero/value", bus.writeback_value_o, last_val);

        @(negedge clk_i);
        drive(FUNCT3_DIV, 32'd1000, 32'd7);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk_i);
            if (c == 1)
                bus.div_request_i = 1'b0;
            if (c == 10)
                reset_i = 1'b1;
        end
        @(negedge clk_i);
        chk("midrst/busy", 32'(bus.busy_o), 32'h0);
        chk("midrst/value", bus.writeback_value_o, 32'h0);
        reset_i = 1'b0;
        pulses  = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (bus.writeback_valid_o)
                pulses++;
        end
        chk("midrst/pulses", 32'(pulses), 32'h0);
        chk("midrst/value2", bus.writeback_value_o, 32'h0);
        last_val = 32'h0;

        run_op("divu_9_3", FUNCT3_DIVU, 32'd9, 32'd3, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
